counter_monitor: RTL and testbench

//  Sits directly downstream of counter_4 and shares its clock C and clear CLR.

---
 rtl/counter_monitor.sv | 120 ++++++++++++
 tb/tb_counter_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// Wrap-around monitor for counter_4: counts wraps of Q in BCD and scans Q, the
// direction letter and the wrap count onto a multiplexed 4-digit 7-segment display.
module counter_monitor #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       C,
  input  logic       CLR,
  input  logic [3:0] Q,
  input  logic       DIR,
  output logic       WRAP,
  output logic [7:0] WCNT,
  output logic       OVF,
  output logic [3:0] AN,
  output logic [6:0] SEG
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_U   = 7'b1000001;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'b1111 : 4'b0000;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  logic [3:0]       q_prev;
  logic             q_valid;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic             wrap_det;
  logic [7:0]       wcnt_next;
  logic             roll;
  logic [3:0]       an_low;
  logic [6:0]       seg_low;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  // Wraps are classified purely from the value pair; DIR plays no part
  always_comb begin
    wrap_det = q_valid && (((q_prev == 4'hF) && (Q == 4'h0)) ||
                           ((q_prev == 4'h0) && (Q == 4'hF)));
  end

  always_comb begin
    wcnt_next = WCNT;
    roll      = 1'b0;
    if (WCNT[3:0] == 4'd9) begin
      wcnt_next[3:0] = 4'd0;
      if (WCNT[7:4] == 4'd9) begin
        wcnt_next[7:4] = 4'd0;
        roll           = 1'b1;
      end else begin
        wcnt_next[7:4] = WCNT[7:4] + 4'd1;
      end
    end else begin
      wcnt_next[3:0] = WCNT[3:0] + 4'd1;
    end
  end

  always_comb begin
    an_low  = 4'b1110;
    seg_low = hex_seg(q_prev);
    case (idx)
      2'd1: begin an_low = 4'b1101; seg_low = DIR ? SEG_U : SEG_D;   end
      2'd2: begin an_low = 4'b1011; seg_low = hex_seg(WCNT[3:0]);    end
      2'd3: begin an_low = 4'b0111; seg_low = hex_seg(WCNT[7:4]);    end
      default: ;
    endcase
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      q_prev  <= 4'h0;
      q_valid <= 1'b0;
      div     <= '0;
      idx     <= 2'd0;
      WRAP    <= 1'b0;
      WCNT    <= 8'h00;
      OVF     <= 1'b0;
      AN      <= AN_OFF;
      SEG     <= SEG_OFF;
    end else begin
      q_prev  <= Q;
      q_valid <= 1'b1;
      WRAP    <= wrap_det;
      if (wrap_det) begin
        WCNT <= wcnt_next;
        if (roll) OVF <= 1'b1;
      end
      if (div == DIV_LAST) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
      AN  <= SEG_ACTIVE_LOW ? an_low  : ~an_low;
      SEG <= SEG_ACTIVE_LOW ? seg_low : ~seg_low;
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: a reference model pushes expected outputs
// per clock edge into a scoreboard queue, popped and compared after the edge.
module tb_counter_monitor;

  localparam int unsigned SCAN_DIV = 4;

  typedef struct {
    logic       wrap;
    logic [7:0] wcnt;
    logic       ovf;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic       C = 1'b0;
  logic       CLR = 1'b1;
  logic [3:0] Q = 4'h0;
  logic       DIR = 1'b1;
  logic       WRAP;
  logic [7:0] WCNT;
  logic       OVF;
  logic [3:0] AN;
  logic [6:0] SEG;

  int total = 0;
  int bad = 0;
  int wrap_seen = 0;

  logic [3:0] m_prev;
  logic       m_valid;
  int         m_cnt;
  logic       m_ovf;
  int         m_edges;
  exp_t       sb[$];

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  counter_monitor #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .C(C), .CLR(CLR), .Q(Q), .DIR(DIR),
    .WRAP(WRAP), .WCNT(WCNT), .OVF(OVF), .AN(AN), .SEG(SEG)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic model_reset();
    m_prev  = 4'h0;
    m_valid = 1'b0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    m_edges = 0;
  endtask

  // Drive one edge's inputs (called at a falling edge), predict, then check after the edge
  task automatic tick(input logic [3:0] q, input logic dir);
    exp_t e;
    exp_t got;
    int   idx;
    logic w;
    Q   = q;
    DIR = dir;
    idx = (m_edges / SCAN_DIV) % 4;
    case (idx)
      0: begin e.an = 4'b1110; e.seg = hex_tab[m_prev]; end
      1: begin e.an = 4'b1101; e.seg = dir ? 7'b1000001 : 7'b0100001; end
      2: begin e.an = 4'b1011; e.seg = hex_tab[m_cnt % 10]; end
      default: begin e.an = 4'b0111; e.seg = hex_tab[m_cnt / 10]; end
    endcase
    w = m_valid && (((m_prev == 4'hF) && (q == 4'h0)) || ((m_prev == 4'h0) && (q == 4'hF)));
    if (w) begin
      if (m_cnt == 99) begin
        m_cnt = 0;
        m_ovf = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    e.wrap = w;
    e.wcnt = to_bcd(m_cnt);
    e.ovf  = m_ovf;
    m_prev  = q;
    m_valid = 1'b1;
    m_edges++;
    sb.push_back(e);
    @(posedge C);
    @(negedge C);
    got = sb.pop_front();
    chk("wrap", 32'(WRAP), 32'(got.wrap));
    chk("wcnt", 32'(WCNT), 32'(got.wcnt));
    chk("ovf",  32'(OVF),  32'(got.ovf));
    chk("an",   32'(AN),   32'(got.an));
    chk("seg",  32'(SEG),  32'(got.seg));
    if (WRAP === 1'b1) wrap_seen++;
  endtask

  initial begin
    bit found;
    model_reset();

    // Reset held with the clock running
    for (int i = 0; i < 4; i++) begin
      @(negedge C);
      chk("rst_an",   32'(AN),   32'hF);
      chk("rst_seg",  32'(SEG),  32'h7F);
      chk("rst_wcnt", 32'(WCNT), 32'h00);
      chk("rst_wrap", 32'(WRAP), 32'h0);
      chk("rst_ovf",  32'(OVF),  32'h0);
    end
    CLR = 1'b0;

    // Scan with Q held at 0: each digit held SCAN_DIV edges
    for (int i = 0; i < 16; i++) tick(4'h0, 1'b1);

    // Up wrap through a full count
    wrap_seen = 0;
    for (int v = 1; v < 16; v++) tick(4'(v), 1'b1);
    tick(4'h0, 1'b1);
    chk("up_wrap_count", 32'(wrap_seen), 32'd1);
    chk("up_wcnt", 32'(WCNT), 32'h01);

    // Down wrap 2 -> 1 -> 0 -> F
    wrap_seen = 0;
    tick(4'h1, 1'b1);
    tick(4'h2, 1'b1);
    tick(4'h1, 1'b0);
    tick(4'h0, 1'b0);
    tick(4'hF, 1'b0);
    chk("down_wrap_count", 32'(wrap_seen), 32'd1);
    chk("down_wcnt", 32'(WCNT), 32'h02);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(4'hF, 1'b0);
      if (AN === 4'b1101) found = 1'b1;
    end
    chk("dir_digit_seen", 32'(found), 32'd1);
    chk("dir_letter_d", 32'(SEG), 32'h21);

    // 100 wraps alternating 0/F: passes 09->10 and 99->00
    for (int i = 0; i < 100; i++) tick((i % 2 == 0) ? 4'h0 : 4'hF, 1'b1);
    chk("roll_wcnt", 32'(WCNT), 32'h02);
    chk("roll_ovf", 32'(OVF), 32'h1);
    for (int i = 0; i < 6; i++) tick(4'hF, 1'b1);
    chk("ovf_sticky", 32'(OVF), 32'h1);

    // Async clear at digit 2 with q_prev=F, then release with Q=0
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (((m_edges / SCAN_DIV) % 4) == 2 && m_prev == 4'hF) found = 1'b1;
      else tick(4'hF, 1'b1);
    end
    chk("reach_idx2", 32'(found), 32'd1);
    #2 CLR = 1'b1;
    #1;
    chk("clr_wcnt", 32'(WCNT), 32'h00);
    chk("clr_ovf",  32'(OVF),  32'h0);
    chk("clr_an",   32'(AN),   32'hF);
    chk("clr_seg",  32'(SEG),  32'h7F);
    chk("clr_wrap", 32'(WRAP), 32'h0);
    @(negedge C);
    CLR = 1'b0;
    model_reset();
    wrap_seen = 0;
    tick(4'h0, 1'b1);
    chk("post_clr_an", 32'(AN), 32'hE);
    for (int i = 0; i < 5; i++) tick(4'h0, 1'b1);
    chk("post_clr_nowrap", 32'(wrap_seen), 32'd0);
    chk("post_clr_wcnt", 32'(WCNT), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
